// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the parametrised SPI slave front-end.
// Frame layout is {cmd[1:0], payload[DATA_W-1:0]}; see spi_slave_gen for the FSM.
package spi_slave_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHK_CMD,
    ST_WRITE,
    ST_READ_ADD,
    ST_READ_DATA
  } state_t;

  // Sub-phases of READ_DATA: receive frame, wait for RAM word, shift it out, idle until SS_n rises.
  typedef enum logic [1:0] {
    PH_RX,
    PH_WAIT,
    PH_SHIFT,
    PH_HOLD
  } rd_phase_t;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  function automatic int frame_len(input int data_w);
    return data_w + 2;
  endfunction

endpackage

// File: rtl/spi_slave_shifter.sv
// SIPO frame shifter and PISO transmit shifter with LSB_FIRST payload reordering.
// frame_next is the frame as it will look once the current sipo_bit is shifted in.
module spi_slave_shifter
  import spi_slave_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int LSB_FIRST = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sipo_en,
  input  logic              sipo_bit,
  input  logic              piso_load,
  input  logic [DATA_W-1:0] piso_data,
  input  logic              piso_shift,
  output logic [DATA_W+1:0] frame_next,
  output logic              piso_bit
);

  localparam int FRAME_W = frame_len(DATA_W);

  logic [FRAME_W-1:0] sipo_reg;
  logic [FRAME_W-1:0] sipo_next;
  logic [DATA_W-1:0]  piso_reg;
  logic [DATA_W-1:0]  payload_rev;
  logic [DATA_W-1:0]  tx_rev;
  logic [DATA_W-1:0]  payload_nat;
  logic [DATA_W-1:0]  tx_ordered;

  assign sipo_next = {sipo_reg[FRAME_W-2:0], sipo_bit};

  generate
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_rev
      assign payload_rev[gi] = sipo_next[DATA_W-1-gi];
      assign tx_rev[gi]      = piso_data[DATA_W-1-gi];
    end
  endgenerate

  // Serial order always runs through the MSB end; reversal restores natural order.
  generate
    if (LSB_FIRST != 0) begin : g_lsb
      assign payload_nat = payload_rev;
      assign tx_ordered  = tx_rev;
    end else begin : g_msb
      assign payload_nat = sipo_next[DATA_W-1:0];
      assign tx_ordered  = piso_data;
    end
  endgenerate

  assign frame_next = {sipo_next[FRAME_W-1:DATA_W], payload_nat};
  assign piso_bit   = piso_reg[DATA_W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sipo_reg <= '0;
      piso_reg <= '0;
    end else begin
      if (sipo_en) begin
        sipo_reg <= sipo_next;
      end
      if (piso_load) begin
        piso_reg <= tx_ordered;
      end else if (piso_shift) begin
        piso_reg <= {piso_reg[DATA_W-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/spi_slave_gen.sv
// Parametrised SPI slave: frame decode FSM, bit counter, read-address tracking, MISO driver.
// Optional burst read mode is enabled by defining SPI_SLAVE_BURST_EN.
module spi_slave_gen
  import spi_slave_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int LSB_FIRST = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              frame_err
);

  localparam int FRAME_W = frame_len(DATA_W);
  localparam int CNT_W   = $clog2(FRAME_W);
  localparam logic [CNT_W-1:0] RX_LAST    = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(DATA_W - 1);

  state_t             state_reg, state_next;
  rd_phase_t          phase_reg, phase_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               done_reg, done_next;
  logic               seen_reg, seen_next;
  logic               rx_valid_reg, rx_valid_next;
  logic               frame_err_reg, frame_err_next;
  logic               miso_reg, miso_next;
  logic [FRAME_W-1:0] rx_data_reg, rx_data_next;

  logic               sipo_en;
  logic               piso_load;
  logic               piso_shift;
  logic               piso_bit;
  logic               rx_busy;
  logic [FRAME_W-1:0] frame_next;

  spi_slave_shifter #(
    .DATA_W   (DATA_W),
    .LSB_FIRST(LSB_FIRST)
  ) u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .sipo_en   (sipo_en),
    .sipo_bit  (MOSI),
    .piso_load (piso_load),
    .piso_data (tx_data),
    .piso_shift(piso_shift),
    .frame_next(frame_next),
    .piso_bit  (piso_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      phase_reg     <= PH_RX;
      cnt_reg       <= '0;
      done_reg      <= 1'b0;
      seen_reg      <= 1'b0;
      rx_valid_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
      miso_reg      <= 1'b0;
      rx_data_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      phase_reg     <= phase_next;
      cnt_reg       <= cnt_next;
      done_reg      <= done_next;
      seen_reg      <= seen_next;
      rx_valid_reg  <= rx_valid_next;
      frame_err_reg <= frame_err_next;
      miso_reg      <= miso_next;
      rx_data_reg   <= rx_data_next;
    end
  end

  // Frame bits after cmd[1] are received identically in WRITE, READ_ADD and READ_DATA.
  assign rx_busy = ((state_reg == ST_WRITE || state_reg == ST_READ_ADD) && !done_reg) ||
                   (state_reg == ST_READ_DATA && phase_reg == PH_RX);

  always_comb begin
    state_next     = state_reg;
    phase_next     = phase_reg;
    cnt_next       = cnt_reg;
    done_next      = done_reg;
    seen_next      = seen_reg;
    rx_valid_next  = 1'b0;
    frame_err_next = 1'b0;
    miso_next      = 1'b0;
    rx_data_next   = rx_data_reg;
    sipo_en        = 1'b0;
    piso_load      = 1'b0;
    piso_shift     = 1'b0;

    if (rx_busy) begin
      if (cnt_reg == RX_LAST) begin
        // The last bit counts even when SS_n rises on the same edge.
        sipo_en       = 1'b1;
        rx_data_next  = frame_next;
        rx_valid_next = 1'b1;
        if (frame_next[FRAME_W-1 -: 2] == CMD_RD_ADDR) begin
          seen_next = 1'b1;
        end
        if (SS_n) begin
          state_next = ST_IDLE;
        end else if (state_reg == ST_READ_DATA) begin
          phase_next = PH_WAIT;
          cnt_next   = '0;
        end else begin
          done_next = 1'b1;
        end
      end else if (SS_n) begin
        state_next     = ST_IDLE;
        frame_err_next = 1'b1;
      end else begin
        sipo_en  = 1'b1;
        cnt_next = cnt_reg + 1'b1;
      end
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (!SS_n) begin
            state_next = ST_CHK_CMD;
          end
        end
        ST_CHK_CMD: begin
          if (SS_n) begin
            state_next     = ST_IDLE;
            frame_err_next = 1'b1;
          end else begin
            sipo_en    = 1'b1;
            done_next  = 1'b0;
            phase_next = PH_RX;
            if (!MOSI) begin
              state_next = ST_WRITE;
            end else if (seen_reg) begin
              state_next = ST_READ_DATA;
            end else begin
              state_next = ST_READ_ADD;
            end
          end
        end
        ST_WRITE, ST_READ_ADD: begin
          if (SS_n) begin
            state_next = ST_IDLE;
          end
        end
        ST_READ_DATA: begin
          case (phase_reg)
            PH_WAIT: begin
              if (SS_n) begin
                state_next = ST_IDLE;
`ifdef SPI_SLAVE_BURST_EN
                // After at least one word, SS_n rising here is the normal end of a burst.
                if (done_reg) begin
                  seen_next = 1'b0;
                end else begin
                  frame_err_next = 1'b1;
                end
`else
                frame_err_next = 1'b1;
`endif
              end else if (tx_valid) begin
                piso_load  = 1'b1;
                phase_next = PH_SHIFT;
                cnt_next   = '0;
              end
            end
            PH_SHIFT: begin
              miso_next  = piso_bit;
              piso_shift = 1'b1;
              if (cnt_reg == SHIFT_LAST) begin
`ifdef SPI_SLAVE_BURST_EN
                done_next = 1'b1;
                if (SS_n) begin
                  state_next = ST_IDLE;
                  seen_next  = 1'b0;
                end else begin
                  rx_valid_next = 1'b1;
                  phase_next    = PH_WAIT;
                  cnt_next      = '0;
                end
`else
                seen_next = 1'b0;
                if (SS_n) begin
                  state_next = ST_IDLE;
                end else begin
                  phase_next = PH_HOLD;
                end
`endif
              end else if (SS_n) begin
                state_next     = ST_IDLE;
                frame_err_next = 1'b1;
                miso_next      = 1'b0;
`ifdef SPI_SLAVE_BURST_EN
                if (done_reg) begin
                  seen_next = 1'b0;
                end
`endif
              end else begin
                cnt_next = cnt_reg + 1'b1;
              end
            end
            PH_HOLD: begin
              if (SS_n) begin
                state_next = ST_IDLE;
              end
            end
            default: begin
              state_next = ST_IDLE;
            end
          endcase
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end

    if (state_next != state_reg) begin
      cnt_next = '0;
    end
  end

  assign MISO      = miso_reg;
  assign rx_valid  = rx_valid_reg;
  assign frame_err = frame_err_reg;
  assign rx_data   = rx_data_reg;

endmodule

// File: tb/tb_spi_slave_gen.sv
// Directed bench for spi_slave_gen: an 8-bit MSB-first instance and a 16-bit LSB-first instance.
// Received frames and MISO bits are checked against scoreboard queues filled at stimulus time.
module tb_spi_slave_gen;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        ss_n_a, mosi_a, miso_a, rx_valid_a, tx_valid_a, frame_err_a;
  logic [9:0]  rx_data_a;
  logic [7:0]  tx_data_a;

  logic        ss_n_b, mosi_b, miso_b, rx_valid_b, tx_valid_b, frame_err_b;
  logic [17:0] rx_data_b;
  logic [15:0] tx_data_b;

  int          checks = 0;
  int          errors = 0;
  logic [17:0] rx_q_a[$];
  logic [17:0] rx_q_b[$];
  logic        miso_q[$];
  int          fe_seen_a = 0;
  int          fe_seen_b = 0;
  int          fe_exp_a  = 0;
  logic [17:0] exp_a, exp_b;

  always #5 clk = ~clk;

  spi_slave_gen #(.DATA_W(8), .LSB_FIRST(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .SS_n(ss_n_a), .MOSI(mosi_a), .MISO(miso_a),
    .rx_data(rx_data_a), .rx_valid(rx_valid_a), .tx_data(tx_data_a),
    .tx_valid(tx_valid_a), .frame_err(frame_err_a)
  );

  spi_slave_gen #(.DATA_W(16), .LSB_FIRST(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .SS_n(ss_n_b), .MOSI(mosi_b), .MISO(miso_b),
    .rx_data(rx_data_b), .rx_valid(rx_valid_b), .tx_data(tx_data_b),
    .tx_valid(tx_valid_b), .frame_err(frame_err_b)
  );

  task automatic chk(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] rev16(input logic [15:0] v);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = v[15-i];
    return r;
  endfunction

  // Scoreboard monitors: every rx_valid pops one expected frame.
  always @(negedge clk) begin
    if (rst_n && rx_valid_a) begin
      checks++;
      assert (rx_q_a.size() != 0) else begin
        errors++;
        $error("FAIL rx_a_unexpected observed=%h expected=none", rx_data_a);
      end
      if (rx_q_a.size() != 0) begin
        exp_a = rx_q_a.pop_front();
        chk("rx_data_a", 18'(rx_data_a), exp_a);
      end
      $display("A rx frame %h", rx_data_a);
    end
    if (rst_n && rx_valid_b) begin
      checks++;
      assert (rx_q_b.size() != 0) else begin
        errors++;
        $error("FAIL rx_b_unexpected observed=%h expected=none", rx_data_b);
      end
      if (rx_q_b.size() != 0) begin
        exp_b = rx_q_b.pop_front();
        chk("rx_data_b", rx_data_b, exp_b);
      end
      $display("B rx frame %h", rx_data_b);
    end
    if (rst_n && frame_err_a) fe_seen_a++;
    if (rst_n && frame_err_b) fe_seen_b++;
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input int sel, input logic ss, input logic m);
    if (sel == 0) begin
      ss_n_a = ss;
      mosi_a = m;
    end else begin
      ss_n_b = ss;
      mosi_b = m;
    end
  endtask

  task automatic send(input int sel, input logic [17:0] f, input int len, input int nsend,
                      input bit ss_on_last);
    drive(sel, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < nsend; i++) begin
      drive(sel, (ss_on_last && i == nsend - 1), f[len-1-i]);
      tick();
    end
  endtask

  task automatic end_frame(input int sel);
    drive(sel, 1'b1, 1'b0);
    tick();
  endtask

  task automatic shift_word(input int sel, input logic [15:0] word, input int len,
                            input bit ss_on_last);
    logic e;
    logic obs;
    for (int i = 0; i < len; i++) miso_q.push_back(sel == 0 ? word[len-1-i] : word[i]);
    if (sel == 0) begin
      tx_valid_a = 1'b1;
      tx_data_a  = word[7:0];
    end else begin
      tx_valid_b = 1'b1;
      tx_data_b  = word;
    end
    tick();
    for (int i = 0; i < len; i++) begin
      // tx_valid stays high with different data: the word must latch only once.
      if (i == 0) begin
        tx_data_a = ~word[7:0];
        tx_data_b = ~word;
      end
      if (i == 2) begin
        tx_valid_a = 1'b0;
        tx_valid_b = 1'b0;
      end
      if (ss_on_last && i == len - 1) drive(sel, 1'b1, 1'b0);
      tick();
      e   = miso_q.pop_front();
      obs = (sel == 0) ? miso_a : miso_b;
      chk("miso_bit", 18'(obs), 18'(e));
    end
    $display("%s tx word %h shifted", sel == 0 ? "A" : "B", word);
  endtask

  initial begin
    rst_n = 1'b1;
    ss_n_a = 1'b1; mosi_a = 1'b0; tx_valid_a = 1'b0; tx_data_a = '0;
    ss_n_b = 1'b1; mosi_b = 1'b0; tx_valid_b = 1'b0; tx_data_b = '0;
    #2 rst_n = 1'b0;
    tick();
    tick();
    chk("reset_rx_valid_a", 18'(rx_valid_a), 18'h0);
    chk("reset_rx_data_a", 18'(rx_data_a), 18'h0);
    chk("reset_miso_a", 18'(miso_a), 18'h0);
    chk("reset_frame_err_a", 18'(frame_err_a), 18'h0);
    chk("reset_rx_data_b", rx_data_b, 18'h0);
    rst_n = 1'b1;
    tick();

    // Write-address frame 00_10100101.
    rx_q_a.push_back(18'h0A5);
    send(0, 18'h0A5, 10, 10, 1'b0);
    chk("wr_addr_rx_valid", 18'(rx_valid_a), 18'h1);
    chk("wr_addr_miso", 18'(miso_a), 18'h0);
    tick();
    chk("wr_addr_rx_valid_1cyc", 18'(rx_valid_a), 18'h0);
    end_frame(0);
    chk("rx_data_hold", 18'(rx_data_a), 18'h0A5);

    // Reset after 4 bits of a frame.
    send(0, 18'h15A, 10, 4, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_rx_data", 18'(rx_data_a), 18'h0);
    chk("midrst_rx_valid", 18'(rx_valid_a), 18'h0);
    chk("midrst_frame_err", 18'(frame_err_a), 18'h0);
    chk("midrst_miso", 18'(miso_a), 18'h0);
    drive(0, 1'b1, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    rx_q_a.push_back(18'h15A);
    send(0, 18'h15A, 10, 10, 1'b0);
    chk("post_rst_rx_valid", 18'(rx_valid_a), 18'h1);
    end_frame(0);

    // Read address, aborted write, then read data.
    rx_q_a.push_back(18'h20F);
    send(0, 18'h20F, 10, 10, 1'b0);
    end_frame(0);
    send(0, 18'h1FF, 10, 6, 1'b0);
    drive(0, 1'b1, 1'b0);
    fe_exp_a++;
    tick();
    chk("abort_frame_err", 18'(frame_err_a), 18'h1);
    chk("abort_no_rx_valid", 18'(rx_valid_a), 18'h0);
    tick();
    chk("abort_frame_err_1cyc", 18'(frame_err_a), 18'h0);
    $display("A aborted write frame");

    rx_q_a.push_back(18'h300);
    send(0, 18'h300, 10, 10, 1'b0);
    chk("rd_data_rx_valid", 18'(rx_valid_a), 18'h1);
`ifdef SPI_SLAVE_BURST_EN
    rx_q_a.push_back(18'h300);
    shift_word(0, 16'h003C, 8, 1'b0);
    rx_q_a.push_back(18'h300);
    shift_word(0, 16'h00C3, 8, 1'b0);
    shift_word(0, 16'h0081, 8, 1'b1);
    tick();
    chk("burst_end_miso", 18'(miso_a), 18'h0);
`else
    shift_word(0, 16'h003C, 8, 1'b0);
    tick();
    chk("post_shift_miso", 18'(miso_a), 18'h0);
    tick();
    chk("post_shift_miso2", 18'(miso_a), 18'h0);
    end_frame(0);
`endif

    // rd_addr_seen cleared: cmd 11 now decodes as read-address and transmits nothing.
    rx_q_a.push_back(18'h3FF);
    send(0, 18'h3FF, 10, 10, 1'b0);
    tx_valid_a = 1'b1;
    tx_data_a  = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("seen_cleared_miso", 18'(miso_a), 18'h0);
    end
    tx_valid_a = 1'b0;
    end_frame(0);

    // 16-bit LSB-first instance.
    rx_q_b.push_back({2'b10, 16'h00FF});
    send(1, {2'b10, rev16(16'h00FF)}, 18, 18, 1'b0);
    end_frame(1);
    rx_q_b.push_back(18'h11234);
    send(1, {2'b01, rev16(16'h1234)}, 18, 18, 1'b1);
    chk("b_last_bit_ss_rx_valid", 18'(rx_valid_b), 18'h1);
    chk("b_last_bit_ss_frame_err", 18'(frame_err_b), 18'h0);
    tick();
    chk("b_last_bit_ss_frame_err2", 18'(frame_err_b), 18'h0);
    chk("b_rx_data_hold", rx_data_b, 18'h11234);
    rx_q_b.push_back(18'h30000);
    send(1, 18'h30000, 18, 18, 1'b0);
    shift_word(1, 16'hA001, 16, 1'b1);
    tick();
    chk("b_post_shift_miso", 18'(miso_b), 18'h0);
    tick();

    chk("frame_err_count_a", 18'(fe_seen_a), 18'(fe_exp_a));
    chk("frame_err_count_b", 18'(fe_seen_b), 18'h0);
    chk("rx_queue_a_drained", 18'(rx_q_a.size()), 18'h0);
    chk("rx_queue_b_drained", 18'(rx_q_b.size()), 18'h0);
    chk("miso_queue_drained", 18'(miso_q.size()), 18'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
